// File: rtl/dsp_vec_pkg.sv
// Shared constants, opcode and sequencer-state types for the vector DSP sequencer.
package dsp_vec_pkg;

    localparam int VEC_LANES  = 8;
    localparam int VEC_DATA_W = 32;
    localparam int FRAC_W     = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DOT = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/dsp_lane_alu.sv
// One Q16.16 lane: wrapping add/sub and truncated signed multiply.
// DOT selects the multiply result so the sequencer can accumulate it.
module dsp_lane_alu
    import dsp_vec_pkg::*;
#(
    parameter int DATA_W = VEC_DATA_W
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic                       unused_prod_bits;

    assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    assign prod  = a_ext * b_ext;

    // Only the Q16.16-aligned middle slice survives; the rest is discarded on purpose.
    assign unused_prod_bits = ^{prod[2*DATA_W-1:DATA_W+FRAC_W], prod[FRAC_W-1:0]};

    always_comb begin
        y = prod[DATA_W+FRAC_W-1:FRAC_W];
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            default: y = prod[DATA_W+FRAC_W-1:FRAC_W];
        endcase
    end

endmodule

// File: rtl/dsp_vec_sequencer.sv
// Vector sequencer: accepts one command, reads two vectors, runs lane-wise
// ADD/SUB/MUL or a serial DOT, then writes the result vector back.
module dsp_vec_sequencer
    import dsp_vec_pkg::*;
#(
    parameter int LANES  = VEC_LANES,
    parameter int ADDR_W = 2,
    parameter int DATA_W = VEC_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_W-1:0]       cmd_ra,
    input  logic [ADDR_W-1:0]       cmd_rb,
    input  logic [ADDR_W-1:0]       cmd_rw,
    output logic [ADDR_W-1:0]       mem_ra,
    output logic [ADDR_W-1:0]       mem_rb,
    output logic [ADDR_W-1:0]       mem_rw,
    output logic                    mem_write,
    input  logic [LANES*DATA_W-1:0] mem_busA,
    input  logic [LANES*DATA_W-1:0] mem_busB,
    output logic [LANES*DATA_W-1:0] mem_busW,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t            state;
    op_t               op_q;
    logic [ADDR_W-1:0] rw_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] opa      [LANES];
    logic [DATA_W-1:0] opb      [LANES];
    logic [DATA_W-1:0] res_q    [LANES];
    logic [DATA_W-1:0] lane_res [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dsp_lane_alu #(.DATA_W(DATA_W)) u_alu (
            .op (op_q),
            .a  (opa[i]),
            .b  (opb[i]),
            .y  (lane_res[i])
        );
        assign mem_busW[i*DATA_W +: DATA_W] = res_q[i];
    end

    // DOT walks the lanes one per cycle, reusing each lane's multiplier output.
    assign acc_next  = acc + lane_res[cnt];
    assign dbg_state = state;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only while idle, so nothing offered during busy is taken or queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            rw_q      <= '0;
            cnt       <= '0;
            acc       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_write <= 1'b0;
            mem_ra    <= '0;
            mem_rb    <= '0;
            mem_rw    <= '0;
            for (int i = 0; i < LANES; i++) begin
                opa[i]   <= '0;
                opb[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            done      <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= op_t'(cmd_op);
                        mem_ra    <= cmd_ra;
                        mem_rb    <= cmd_rb;
                        rw_q      <= cmd_rw;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    for (int i = 0; i < LANES; i++) begin
                        opa[i] <= mem_busA[i*DATA_W +: DATA_W];
                        opb[i] <= mem_busB[i*DATA_W +: DATA_W];
                    end
                    acc   <= '0;
                    cnt   <= '0;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == OP_DOT) begin
                        acc <= acc_next;
                        if (cnt == CNT_W'(LANES - 1)) begin
                            res_q[0] <= acc_next;
                            for (int i = 1; i < LANES; i++) res_q[i] <= '0;
                            mem_rw    <= rw_q;
                            mem_write <= 1'b1;
                            done      <= 1'b1;
                            state     <= S_WRITE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        for (int i = 0; i < LANES; i++) res_q[i] <= lane_res[i];
                        mem_rw    <= rw_q;
                        mem_write <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_vec_sequencer.sv
// Self-checking bench for dsp_vec_sequencer: behavioural vector memory,
// reference model with expected-result queue, and cycle-exact write checks.
module tb_dsp_vec_sequencer;

    localparam int LANES = 8;
    localparam int DW    = 32;
    localparam int VW    = LANES * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [1:0]    cmd_ra = '0;
    logic [1:0]    cmd_rb = '0;
    logic [1:0]    cmd_rw = '0;
    logic [1:0]    mem_ra, mem_rb, mem_rw;
    logic          mem_write;
    logic [VW-1:0] mem_busA, mem_busB, mem_busW;
    logic          busy, done;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem     [4][LANES];
    logic [DW-1:0] ref_mem [4][LANES];

    logic [VW-1:0] exp_q     [$];
    logic [1:0]    exp_rw_q  [$];
    int            exp_cyc_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_lo  = -1;
    int busy_hi  = -1;
    bit mon_en   = 1'b0;

    dsp_vec_sequencer u_dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rw    (cmd_rw),
        .mem_ra    (mem_ra),
        .mem_rb    (mem_rb),
        .mem_rw    (mem_rw),
        .mem_write (mem_write),
        .mem_busA  (mem_busA),
        .mem_busB  (mem_busB),
        .mem_busW  (mem_busW),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset infrastructure
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // vector memory: combinational reads, write on rising edge
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mem_busA[i*DW +: DW] = mem[mem_ra][i];
            mem_busB[i*DW +: DW] = mem[mem_rb][i];
        end
    end

    always @(posedge clk) begin
        if (mem_write)
            for (int i = 0; i < LANES; i++) mem[mem_rw][i] = mem_busW[i*DW +: DW];
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] model(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb);
        logic [VW-1:0]      r;
        logic [DW-1:0]      a, b, acc;
        logic signed [63:0] sa, sb, p;
        r   = '0;
        acc = '0;
        for (int i = 0; i < LANES; i++) begin
            a  = ref_mem[ra][i];
            b  = ref_mem[rb][i];
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            p  = sa * sb;
            case (op)
                2'b00:   r[i*DW +: DW] = a + b;
                2'b01:   r[i*DW +: DW] = a - b;
                2'b10:   r[i*DW +: DW] = p[47:16];
                default: acc = acc + p[47:16];
            endcase
        end
        if (op == 2'b11) r[DW-1:0] = acc;
        return r;
    endfunction

    // scoreboard: write strobe, done, handshake and result vector every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            logic          exp_w;
            logic          exp_busy;
            logic [VW-1:0] w;
            if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                check("write_missing", VW'(1'b0), VW'(1'b1));
                void'(exp_q.pop_front());
                void'(exp_rw_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            exp_w    = (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc);
            exp_busy = (cyc >= busy_lo && cyc <= busy_hi);
            check("mem_write", VW'(mem_write), VW'(exp_w));
            check("done", VW'(done), VW'(exp_w));
            check("busy", VW'(busy), VW'(exp_busy));
            check("cmd_ready", VW'(cmd_ready), VW'(!exp_busy));
            if (exp_w) begin
                w = exp_q.pop_front();
                check("busW", mem_busW, w);
                check("mem_rw", VW'(mem_rw), VW'(exp_rw_q.pop_front()));
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    // driver: wait for ready, present one command, log the expected result
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                            input logic [1:0] rw, input bit use_spec, input logic [VW-1:0] spec_w,
                            input bit noise);
        int            guard;
        int            t;
        logic [VW-1:0] m;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", VW'(cmd_ready), VW'(1'b1));
            return;
        end
        #1;
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rw = rw; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        t = cyc;
        m = model(op, ra, rb);
        busy_lo = t;
        busy_hi = t + ((op == 2'b11) ? 9 : 2);
        exp_q.push_back(use_spec ? spec_w : m);
        exp_rw_q.push_back(rw);
        exp_cyc_q.push_back(busy_hi);
        for (int i = 0; i < LANES; i++) ref_mem[rw][i] = m[i*DW +: DW];
        if (noise) begin
            repeat (busy_hi - t) begin
                @(negedge clk);
                #1;
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_rw    = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) check("drain_timeout", VW'(exp_q.size()), VW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [VW-1:0] v;
        logic [DW-1:0] saved [LANES];
        logic [1:0]    rop, rra, rrb, rrw;

        for (int k = 0; k < 4; k++)
            for (int i = 0; i < LANES; i++) begin
                mem[k][i]     = '0;
                ref_mem[k][i] = '0;
            end
        for (int i = 0; i < LANES; i++) begin
            mem[0][i] = DW'((2*i + 1) << 16);
            mem[1][i] = DW'((2*i + 2) << 16);
            ref_mem[0][i] = mem[0][i];
            ref_mem[1][i] = mem[1][i];
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", VW'(cmd_ready), VW'(1'b1));
        check("rst_busy", VW'(busy), VW'(1'b0));
        check("rst_done", VW'(done), VW'(1'b0));
        check("rst_mem_write", VW'(mem_write), VW'(1'b0));
        check("rst_addrs", VW'({mem_ra, mem_rb, mem_rw}), VW'(0));
        check("rst_busW", mem_busW, '0);
        check("rst_state", VW'(dbg_state), VW'(0));
        mon_en = 1'b1;

        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'((4*i + 3) << 16);
        send_cmd(2'b00, 2'd0, 2'd1, 2'd2, 1'b1, v, 1'b0);

        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 32'h0001_0000;
        send_cmd(2'b01, 2'd1, 2'd0, 2'd3, 1'b1, v, 1'b0);
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 32'hFFFF_0000;
        send_cmd(2'b01, 2'd0, 2'd1, 2'd3, 1'b1, v, 1'b0);

        v = {32'h00F0_0000, 32'h00B6_0000, 32'h0084_0000, 32'h005A_0000,
             32'h0038_0000, 32'h001E_0000, 32'h000C_0000, 32'h0002_0000};
        send_cmd(2'b10, 2'd0, 2'd1, 2'd2, 1'b1, v, 1'b0);

        v = '0;
        v[DW-1:0] = 32'h02E8_0000;
        send_cmd(2'b11, 2'd0, 2'd1, 2'd3, 1'b1, v, 1'b1);

        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'((4*i + 2) << 16);
        send_cmd(2'b00, 2'd0, 2'd0, 2'd0, 1'b1, v, 1'b0);
        wait_drain();
        for (int i = 0; i < LANES; i++)
            check($sformatf("inplace_mem0_lane%0d", i), VW'(mem[0][i]), VW'((4*i + 2) << 16));

        for (int k = 1; k < 4; k++)
            for (int i = 0; i < LANES; i++) begin
                mem[k][i]     = $urandom;
                ref_mem[k][i] = mem[k][i];
            end
        for (int n = 0; n < 16; n++) begin
            rop = 2'($urandom_range(0, 3));
            rra = 2'($urandom_range(0, 3));
            rrb = 2'($urandom_range(0, 3));
            rrw = 2'($urandom_range(0, 3));
            send_cmd(rop, rra, rrb, rrw, 1'b0, '0, n[0]);
        end
        wait_drain();

        for (int i = 0; i < LANES; i++) saved[i] = ref_mem[3][i];
        send_cmd(2'b11, 2'd1, 2'd2, 2'd3, 1'b0, '0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_rw_q.delete();
        exp_cyc_q.delete();
        busy_hi = -1;
        for (int i = 0; i < LANES; i++) ref_mem[3][i] = saved[i];
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", VW'(cmd_ready), VW'(1'b1));
        check("abort_state", VW'(dbg_state), VW'(0));
        repeat (12) @(negedge clk);
        for (int i = 0; i < LANES; i++)
            check($sformatf("abort_mem3_lane%0d", i), VW'(mem[3][i]), VW'(saved[i]));

        send_cmd(2'b11, 2'd2, 2'd3, 2'd1, 1'b0, '0, 1'b0);
        send_cmd(2'b10, 2'd3, 2'd1, 2'd2, 1'b0, '0, 1'b0);
        wait_drain();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
